// File: rtl/demux_i1_o4_pack_if.sv
// Byte-in / word-out handshake bundle for the 1-to-4 lane unpacker.
// master drives bytes and accepts words; slave is the unpacker itself.
interface demux_i1_o4_pack_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_a0;
  logic [DATA_W-1:0] out_a1;
  logic [DATA_W-1:0] out_a2;
  logic [DATA_W-1:0] out_a3;
  logic [3:0]        out_keep;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        lane_sel;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_a0, out_a1, out_a2, out_a3, out_keep, out_valid, lane_sel
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_a0, out_a1, out_a2, out_a3, out_keep, out_valid, lane_sel
  );
endinterface

// File: rtl/demux_i1_o4_pack.sv
// Steers a serial byte stream into four lanes under a rotating lane select and
// emits 4-byte words with a keep mask; one assembly word plus one output word.
module demux_i1_o4_pack #(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  demux_i1_o4_pack_if.slave bus
);

  logic [3:0][DATA_W-1:0] asm_q, asm_d;
  logic [3:0]             asm_keep_q, asm_keep_d;
  logic [1:0]             lane_sel_q, lane_sel_d;
  logic                   pending_q, pending_d;
  logic [3:0][DATA_W-1:0] out_q, out_d;
  logic [3:0]             out_keep_q, out_keep_d;
  logic                   out_valid_q, out_valid_d;

  logic                   acc;
  logic                   complete;
  logic                   drain;
  logic                   slot_free;
  logic [3:0][DATA_W-1:0] word_data;
  logic [3:0]             word_keep;

  // word_data/word_keep are the assembly contents including this cycle's byte,
  // so a completing word can bypass straight into the output register.
  always_comb begin
    acc       = bus.in_valid & ~pending_q;
    complete  = acc & ((lane_sel_q == 2'd3) | bus.in_last);
    drain     = out_valid_q & bus.out_ready;
    slot_free = ~out_valid_q | bus.out_ready;

    word_data = asm_q;
    word_keep = asm_keep_q;
    if (acc) begin
      word_data[lane_sel_q] = bus.in_data;
      word_keep[lane_sel_q] = 1'b1;
    end

    asm_d       = word_data;
    asm_keep_d  = word_keep;
    lane_sel_d  = lane_sel_q;
    pending_d   = pending_q;
    out_d       = out_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q & ~drain;

    if (acc) begin
      lane_sel_d = complete ? 2'd0 : lane_sel_q + 2'd1;
    end

    // A completed word that cannot move yet parks in assembly and stalls input.
    if (complete && slot_free) begin
      out_d       = word_data;
      out_keep_d  = word_keep;
      out_valid_d = 1'b1;
      asm_d       = '0;
      asm_keep_d  = '0;
    end else if (complete) begin
      pending_d = 1'b1;
    end else if (pending_q && drain) begin
      out_d       = asm_q;
      out_keep_d  = asm_keep_q;
      out_valid_d = 1'b1;
      pending_d   = 1'b0;
      asm_d       = '0;
      asm_keep_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      asm_keep_q  <= '0;
      lane_sel_q  <= '0;
      pending_q   <= 1'b0;
      out_q       <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      asm_keep_q  <= asm_keep_d;
      lane_sel_q  <= lane_sel_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = ~pending_q;
  assign bus.lane_sel  = lane_sel_q;
  assign bus.out_a0    = out_q[0];
  assign bus.out_a1    = out_q[1];
  assign bus.out_a2    = out_q[2];
  assign bus.out_a3    = out_q[3];
  assign bus.out_keep  = out_keep_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_demux_i1_o4_pack.sv
// Bench for demux_i1_o4_pack: a word-queue reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_demux_i1_o4_pack;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  demux_i1_o4_pack_if #(.DATA_W(8)) bus ();

  demux_i1_o4_pack #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: completed words wait in a queue whose head is the presented word;
  // two queued words means one is parked and input is stalled.
  logic [35:0] exp_q[$];
  logic [7:0]  part[4];
  int          part_n;

  task automatic check_output(input string name, input logic [35:0] act, input logic [35:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] cur_word();
    return {bus.out_keep, bus.out_a3, bus.out_a2, bus.out_a1, bus.out_a0};
  endfunction

  initial begin
    logic        m_acc;
    logic [35:0] w;
    exp_q.delete();
    part_n = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        part_n = 0;
      end else begin
        m_acc = bus.in_valid && (exp_q.size() < 2);
        if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
        if (m_acc) begin
          part[part_n] = bus.in_data;
          part_n++;
          if (part_n == 4 || bus.in_last) begin
            w = '0;
            for (int i = 0; i < 4; i++) begin
              if (i < part_n) w[i*8 +: 8] = part[i];
            end
            w[35:32] = 4'((1 << part_n) - 1);
            exp_q.push_back(w);
            part_n = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_output("out_valid", 36'(bus.out_valid), 36'(exp_q.size() > 0));
        check_output("in_ready", 36'(bus.in_ready), 36'(exp_q.size() < 2));
        check_output("lane_sel", 36'(bus.lane_sel), 36'(part_n));
        if (exp_q.size() > 0) check_output("word", cur_word(), exp_q[0]);
      end
    end
  end

  // Holds the byte on the input until an edge accepts it; leaves in_valid high
  // so consecutive calls stream back to back.
  task automatic apply_stimulus(input logic [7:0] d, input logic last);
    logic got;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
      if (got) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL accept_timeout: byte %h not accepted, required within 64 cycles", d);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    check_output("rst_word", cur_word(), 36'h0);
    check_output("rst_out_valid", 36'(bus.out_valid), 36'h0);
    check_output("rst_in_ready", 36'(bus.in_ready), 36'h1);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mid-word reset discards the partial word immediately.
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_lane_sel", 36'(bus.lane_sel), 36'h0);
    check_output("arst_in_ready", 36'(bus.in_ready), 36'h1);
    check_output("arst_out_valid", 36'(bus.out_valid), 36'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(8'h03, 1'b1);
    check_output("post_rst_word", cur_word(), 36'h1_00_00_00_03);
    idle(2);

    // Streaming at one byte per cycle.
    apply_stimulus(8'h11, 1'b0);
    apply_stimulus(8'h22, 1'b0);
    apply_stimulus(8'h33, 1'b0);
    apply_stimulus(8'h44, 1'b0);
    check_output("stream_w1", cur_word(), 36'hF_44_33_22_11);
    check_output("stream_w1_valid", 36'(bus.out_valid), 36'h1);
    apply_stimulus(8'h55, 1'b0);
    apply_stimulus(8'h66, 1'b0);
    apply_stimulus(8'h77, 1'b0);
    apply_stimulus(8'h88, 1'b0);
    check_output("stream_w2", cur_word(), 36'hF_88_77_66_55);
    idle(2);

    // Flush of a partial word, then the next byte restarts at lane 0.
    apply_stimulus(8'hA1, 1'b0);
    apply_stimulus(8'hA2, 1'b1);
    check_output("flush_word", cur_word(), 36'h3_00_00_A2_A1);
    apply_stimulus(8'hB1, 1'b1);
    check_output("flush_next", cur_word(), 36'h1_00_00_00_B1);
    idle(2);

    // Backpressure: second word parks and stalls input until one drain.
    bus.out_ready = 1'b0;
    apply_stimulus(8'hE1, 1'b0);
    apply_stimulus(8'hE2, 1'b0);
    apply_stimulus(8'hE3, 1'b0);
    apply_stimulus(8'hE4, 1'b0);
    apply_stimulus(8'hF1, 1'b0);
    apply_stimulus(8'hF2, 1'b0);
    apply_stimulus(8'hF3, 1'b0);
    apply_stimulus(8'hF4, 1'b0);
    check_output("bp_in_ready", 36'(bus.in_ready), 36'h0);
    idle(3);
    check_output("bp_held", cur_word(), 36'hF_E4_E3_E2_E1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check_output("bp_w2", cur_word(), 36'hF_F4_F3_F2_F1);
    check_output("bp_w2_valid", 36'(bus.out_valid), 36'h1);
    check_output("bp_in_ready_back", 36'(bus.in_ready), 36'h1);
    idle(2);
    bus.out_ready = 1'b1;
    idle(2);

    // Gaps between bytes; lane select holds across them.
    apply_stimulus(8'hC1, 1'b0);
    idle(1);
    check_output("gap_lane_sel", 36'(bus.lane_sel), 36'h1);
    apply_stimulus(8'hC2, 1'b0);
    idle(1);
    apply_stimulus(8'hC3, 1'b0);
    idle(1);
    apply_stimulus(8'hC4, 1'b0);
    check_output("gap_word", cur_word(), 36'hF_C4_C3_C2_C1);
    idle(2);

    apply_stimulus(8'hD1, 1'b1);
    check_output("single_byte", cur_word(), 36'h1_00_00_00_D1);
    idle(2);

    // Randomized soak checked by the model every cycle.
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.in_last   = ($urandom_range(0, 7) == 0);
      bus.out_ready = (c > 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
